// File: rtl/ahb_mtx_pkg.sv
// ahb_mtx_pkg
// Shared encodings for the AHB matrix input stage:
//   - HTRANS transfer types (IDLE/BUSY/NONSEQ/SEQ)
//   - HRESP responses (OKAY/ERROR)
//   - HBURST encodings used by the matrix
//   - input-stage state enum (IDLE/PEND/DATA)
package ahb_mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  // ST_PEND: a captured transfer waits for the output-stage arbiter.
  // ST_DATA: a granted transfer has its data phase outstanding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_DATA = 2'b10
  } in_state_t;

endpackage

// File: rtl/ahb_mtx_in_hold_reg.sv
// ahb_mtx_in_hold_reg
// Holding register for one AHB address phase. Loads every field when
// i_cap_en is high; i_srst (synchronous, active-high) clears all fields
// and takes priority over capture.
// Ports:
//   i_clk, i_srst, i_cap_en        clock, clear, capture enable
//   i_addr .. i_mastlock           live address-phase fields
//   o_addr .. o_mastlock           held address-phase fields
module ahb_mtx_in_hold_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_cap_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_trans,
  input  logic              i_write,
  input  logic [2:0]        i_size,
  input  logic [2:0]        i_burst,
  input  logic [3:0]        i_prot,
  input  logic              i_mastlock,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_trans,
  output logic              o_write,
  output logic [2:0]        o_size,
  output logic [2:0]        o_burst,
  output logic [3:0]        o_prot,
  output logic              o_mastlock
);

  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_trans;
  logic              r_write;
  logic [2:0]        r_size;
  logic [2:0]        r_burst;
  logic [3:0]        r_prot;
  logic              r_mastlock;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_addr     <= '0;
      r_trans    <= '0;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_burst    <= '0;
      r_prot     <= '0;
      r_mastlock <= 1'b0;
    end else if (i_cap_en) begin
      r_addr     <= i_addr;
      r_trans    <= i_trans;
      r_write    <= i_write;
      r_size     <= i_size;
      r_burst    <= i_burst;
      r_prot     <= i_prot;
      r_mastlock <= i_mastlock;
    end
  end

  assign o_addr     = r_addr;
  assign o_trans    = r_trans;
  assign o_write    = r_write;
  assign o_size     = r_size;
  assign o_burst    = r_burst;
  assign o_prot     = r_prot;
  assign o_mastlock = r_mastlock;

endmodule

// File: rtl/ahb_mtx_in_stage.sv
// ahb_mtx_in_stage
// AHB matrix input stage for one master port. A new transfer is either
// forwarded straight to the matrix when the arbiter grants it in the same
// cycle, or captured into a holding register and replayed (with the master
// stalled) until it is granted. Data-phase ready/response from the selected
// slave are routed back to the master.
// Ports:
//   HCLK, HRESET                    clock, synchronous active-high reset
//   HSELS..HREADYS                  master-side address phase and HREADY
//   HREADYOUTS, HRESPS              ready/response back to the master
//   req_out, grant_in               handshake with the output-stage arbiter
//   HADDRO..HMASTLOCKO              address phase presented to the matrix
//   dphase_ready_in, dphase_resp_in data-phase status of the selected slave
module ahb_mtx_in_stage
  import ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS,
  output logic              req_out,
  input  logic              grant_in,
  output logic [ADDR_W-1:0] HADDRO,
  output logic [1:0]        HTRANSO,
  output logic              HWRITEO,
  output logic [2:0]        HSIZEO,
  output logic [2:0]        HBURSTO,
  output logic [3:0]        HPROTO,
  output logic              HMASTLOCKO,
  input  logic              dphase_ready_in,
  input  logic [1:0]        dphase_resp_in
);

  in_state_t r_state;
  in_state_t w_state_next;
  logic      w_new_tran;
  logic      w_capture;

  logic [ADDR_W-1:0] w_hold_addr;
  logic [1:0]        w_hold_trans;
  logic              w_hold_write;
  logic [2:0]        w_hold_size;
  logic [2:0]        w_hold_burst;
  logic [3:0]        w_hold_prot;
  logic              w_hold_mastlock;

  // NONSEQ or SEQ accepted from the master this cycle.
  assign w_new_tran = HSELS & HTRANSS[1] & HREADYS;

  // Capture happens only when a fresh transfer is accepted but not granted;
  // while pending, live master inputs are ignored.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_new_tran) begin
          if (grant_in) begin
            w_state_next = ST_DATA;
          end else begin
            w_state_next = ST_PEND;
            w_capture    = 1'b1;
          end
        end
      end
      ST_PEND: begin
        if (grant_in) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (dphase_ready_in) begin
          if (!w_new_tran) begin
            w_state_next = ST_IDLE;
          end else if (grant_in) begin
            w_state_next = ST_DATA;
          end else begin
            w_state_next = ST_PEND;
            w_capture    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  ahb_mtx_in_hold_reg #(
    .ADDR_W (ADDR_W)
  ) u_hold (
    .i_clk      (HCLK),
    .i_srst     (HRESET),
    .i_cap_en   (w_capture),
    .i_addr     (HADDRS),
    .i_trans    (HTRANSS),
    .i_write    (HWRITES),
    .i_size     (HSIZES),
    .i_burst    (HBURSTS),
    .i_prot     (HPROTS),
    .i_mastlock (HMASTLOCKS),
    .o_addr     (w_hold_addr),
    .o_trans    (w_hold_trans),
    .o_write    (w_hold_write),
    .o_size     (w_hold_size),
    .o_burst    (w_hold_burst),
    .o_prot     (w_hold_prot),
    .o_mastlock (w_hold_mastlock)
  );

  // Address phase: held copy while pending, live pass-through otherwise so
  // an immediately granted transfer costs no extra cycle.
  always_comb begin
    HADDRO     = HADDRS;
    HTRANSO    = HTRANSS;
    HWRITEO    = HWRITES;
    HSIZEO     = HSIZES;
    HBURSTO    = HBURSTS;
    HPROTO     = HPROTS;
    HMASTLOCKO = HMASTLOCKS;
    if (r_state == ST_PEND) begin
      HADDRO     = w_hold_addr;
      HTRANSO    = w_hold_trans;
      HWRITEO    = w_hold_write;
      HSIZEO     = w_hold_size;
      HBURSTO    = w_hold_burst;
      HPROTO     = w_hold_prot;
      HMASTLOCKO = w_hold_mastlock;
    end
  end

  // Master is stalled for every pending cycle, including the grant cycle,
  // because the held transfer only enters its data phase after that edge.
  always_comb begin
    req_out    = (r_state == ST_PEND) | w_new_tran;
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    case (r_state)
      ST_PEND: HREADYOUTS = 1'b0;
      ST_DATA: begin
        HREADYOUTS = dphase_ready_in;
        HRESPS     = dphase_resp_in;
      end
      default: HREADYOUTS = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ahb_mtx_in_stage.sv
// tb_ahb_mtx_in_stage
// Directed bench for ahb_mtx_in_stage. The stimulus process drives inputs
// just after each rising edge and pushes the expected outputs for that
// cycle into a queue; a monitor samples on the falling edge, pops and
// compares.
module tb_ahb_mtx_in_stage;
  import ahb_mtx_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  logic        req_out;
  logic        grant_in;
  logic [31:0] HADDRO;
  logic [1:0]  HTRANSO;
  logic        HWRITEO;
  logic [2:0]  HSIZEO;
  logic [2:0]  HBURSTO;
  logic [3:0]  HPROTO;
  logic        HMASTLOCKO;
  logic        dphase_ready_in;
  logic [1:0]  dphase_resp_in;

  always #5 HCLK = ~HCLK;

  ahb_mtx_in_stage #(.ADDR_W(32)) dut (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .HSELS           (HSELS),
    .HADDRS          (HADDRS),
    .HTRANSS         (HTRANSS),
    .HWRITES         (HWRITES),
    .HSIZES          (HSIZES),
    .HBURSTS         (HBURSTS),
    .HPROTS          (HPROTS),
    .HMASTLOCKS      (HMASTLOCKS),
    .HREADYS         (HREADYS),
    .HREADYOUTS      (HREADYOUTS),
    .HRESPS          (HRESPS),
    .req_out         (req_out),
    .grant_in        (grant_in),
    .HADDRO          (HADDRO),
    .HTRANSO         (HTRANSO),
    .HWRITEO         (HWRITEO),
    .HSIZEO          (HSIZEO),
    .HBURSTO         (HBURSTO),
    .HPROTO          (HPROTO),
    .HMASTLOCKO      (HMASTLOCKO),
    .dphase_ready_in (dphase_ready_in),
    .dphase_resp_in  (dphase_resp_in)
  );

  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic        req;
    logic        achk;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        wr;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Monitor: compare whatever expectation is queued for this cycle.
  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      logic  ok;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      ok = (HREADYOUTS === e.rdy) && (HRESPS === e.resp) && (req_out === e.req);
      if (e.achk)
        ok = ok && (HADDRO === e.addr) && (HTRANSO === e.trans) &&
             (HBURSTO === e.burst) && (HWRITEO === e.wr);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: got rdy=%b resp=%h req=%b addr=%h trans=%h burst=%h wr=%b, expected rdy=%b resp=%h req=%b addr=%h trans=%h burst=%h wr=%b (addr fields checked=%b)",
                 nm, HREADYOUTS, HRESPS, req_out, HADDRO, HTRANSO, HBURSTO, HWRITEO,
                 e.rdy, e.resp, e.req, e.addr, e.trans, e.burst, e.wr, e.achk);
      end else begin
        $display("check %s: rdy=%b resp=%h req=%b addr=%h trans=%h ok",
                 nm, HREADYOUTS, HRESPS, req_out, HADDRO, HTRANSO);
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Queue the expectation for the current cycle, then advance one cycle.
  task automatic step(input string nm, input logic rdy, input logic [1:0] resp,
                      input logic req, input logic achk, input logic [31:0] addr,
                      input logic [1:0] trans, input logic [2:0] burst, input logic wr);
    exp_t e;
    e.rdy = rdy; e.resp = resp; e.req = req; e.achk = achk;
    e.addr = addr; e.trans = trans; e.burst = burst; e.wr = wr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
  endtask

  task automatic master(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                        input logic wr, input logic [2:0] bu, input logic rdy);
    HSELS   = sel;
    HTRANSS = tr;
    HADDRS  = a;
    HWRITES = wr;
    HBURSTS = bu;
    HREADYS = rdy;
  endtask

  initial begin
    HRESET = 1'b1; HSIZES = 3'b010; HPROTS = 4'b0011; HMASTLOCKS = 1'b0;
    grant_in = 1'b0; dphase_ready_in = 1'b1; dphase_resp_in = HRESP_OKAY;
    master(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 1'b1);
    tick(); tick();
    HRESET = 1'b0;
    step("rst_init", 1'b1, HRESP_OKAY, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);

    // Reset while pending
    master(1'b1, HTRANS_NONSEQ, 32'h1111_0000, 1'b0, HBURST_SINGLE, 1'b1);
    step("rst_pre_idle", 1'b1, HRESP_OKAY, 1'b1, 1'b1, 32'h1111_0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    master(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 1'b0);
    step("rst_pre_pend", 1'b0, HRESP_OKAY, 1'b1, 1'b1, 32'h1111_0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    HRESET = 1'b1;
    tick(); tick();
    HRESET = 1'b0; HREADYS = 1'b1;
    step("rst_in_pend", 1'b1, HRESP_OKAY, 1'b0, 1'b1, 32'h0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);

    // Immediate grant
    master(1'b1, HTRANS_NONSEQ, 32'h2000_0010, 1'b0, HBURST_SINGLE, 1'b1);
    grant_in = 1'b1;
    step("imm_addr", 1'b1, HRESP_OKAY, 1'b1, 1'b1, 32'h2000_0010, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    master(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 1'b0);
    grant_in = 1'b0; dphase_ready_in = 1'b0;
    step("imm_wait1", 1'b0, HRESP_OKAY, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);
    step("imm_wait2", 1'b0, HRESP_OKAY, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);
    dphase_ready_in = 1'b1;
    step("imm_done", 1'b1, HRESP_OKAY, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);
    HREADYS = 1'b1;
    step("imm_idle", 1'b1, HRESP_OKAY, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);

    // Deferred grant
    master(1'b1, HTRANS_NONSEQ, 32'h4000_0004, 1'b1, HBURST_SINGLE, 1'b1);
    step("def_addr", 1'b1, HRESP_OKAY, 1'b1, 1'b1, 32'h4000_0004, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    master(1'b1, HTRANS_SEQ, 32'h5555_5555, 1'b0, HBURST_INCR, 1'b0);
    step("def_pend1", 1'b0, HRESP_OKAY, 1'b1, 1'b1, 32'h4000_0004, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    step("def_pend2", 1'b0, HRESP_OKAY, 1'b1, 1'b1, 32'h4000_0004, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    step("def_pend3", 1'b0, HRESP_OKAY, 1'b1, 1'b1, 32'h4000_0004, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    grant_in = 1'b1;
    step("def_grant", 1'b0, HRESP_OKAY, 1'b1, 1'b1, 32'h4000_0004, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    grant_in = 1'b0;
    master(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 1'b1);
    step("def_data", 1'b1, HRESP_OKAY, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);
    step("def_idle", 1'b1, HRESP_OKAY, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);

    // Back-to-back burst beat denied at data completion
    master(1'b1, HTRANS_NONSEQ, 32'h3000_0000, 1'b0, HBURST_INCR4, 1'b1);
    grant_in = 1'b1;
    step("b2b_first", 1'b1, HRESP_OKAY, 1'b1, 1'b1, 32'h3000_0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b0);
    master(1'b1, HTRANS_SEQ, 32'h3000_0004, 1'b0, HBURST_INCR4, 1'b1);
    grant_in = 1'b0;
    step("b2b_seq", 1'b1, HRESP_OKAY, 1'b1, 1'b1, 32'h3000_0004, HTRANS_SEQ, HBURST_INCR4, 1'b0);
    master(1'b0, HTRANS_IDLE, 32'hDEAD_0000, 1'b1, HBURST_SINGLE, 1'b0);
    step("b2b_pend", 1'b0, HRESP_OKAY, 1'b1, 1'b1, 32'h3000_0004, HTRANS_SEQ, HBURST_INCR4, 1'b0);
    grant_in = 1'b1;
    step("b2b_grant", 1'b0, HRESP_OKAY, 1'b1, 1'b1, 32'h3000_0004, HTRANS_SEQ, HBURST_INCR4, 1'b0);
    grant_in = 1'b0; HREADYS = 1'b1;
    step("b2b_data", 1'b1, HRESP_OKAY, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);
    dphase_ready_in = 1'b0;
    step("b2b_once", 1'b1, HRESP_OKAY, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);
    dphase_ready_in = 1'b1;

    // Two-cycle ERROR response
    master(1'b1, HTRANS_NONSEQ, 32'h6000_0000, 1'b1, HBURST_SINGLE, 1'b1);
    grant_in = 1'b1;
    step("err_addr", 1'b1, HRESP_OKAY, 1'b1, 1'b1, 32'h6000_0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    grant_in = 1'b0;
    master(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 1'b0);
    dphase_ready_in = 1'b0; dphase_resp_in = HRESP_ERROR;
    step("err_cyc1", 1'b0, HRESP_ERROR, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);
    dphase_ready_in = 1'b1; HREADYS = 1'b1;
    step("err_cyc2", 1'b1, HRESP_ERROR, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);
    step("err_idle", 1'b1, HRESP_OKAY, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);
    dphase_resp_in = HRESP_OKAY;

    // Spurious grant with no request; slave held not-ready so a wrong move
    // into DATA would show as HREADYOUTS low.
    grant_in = 1'b1; dphase_ready_in = 1'b0;
    step("spur_1", 1'b1, HRESP_OKAY, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);
    step("spur_2", 1'b1, HRESP_OKAY, 1'b0, 1'b0, 32'h0, 2'b0, 3'b0, 1'b0);
    grant_in = 1'b0; dphase_ready_in = 1'b1;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge HCLK);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
